// File: rtl/div_sequencer_if.sv
// Request/response bundle between the execute stage and the divide unit.
//   start, flush       : one-cycle request and pipeline abort
//   opcode/funct7/3    : instruction fields decoded on the start edge
//   accuracy_level     : approximation CSR, bits [4:0] used
//   bus_rs1, bus_rs2   : dividend and divisor, sampled on the start edge
//   div_unit_busy      : operation in flight (stall)
//   div_done           : one-cycle result strobe
//   div_output         : registered result, held until the next div_done
interface div_sequencer_if;
  logic        start;
  logic        flush;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [7:0]  accuracy_level;
  logic [31:0] bus_rs1;
  logic [31:0] bus_rs2;
  logic        div_unit_busy;
  logic        div_done;
  logic [31:0] div_output;

  modport master (
    output start, flush, opcode, funct7, funct3, accuracy_level, bus_rs1, bus_rs2,
    input  div_unit_busy, div_done, div_output
  );

  modport slave (
    input  start, flush, opcode, funct7, funct3, accuracy_level, bus_rs1, bus_rs2,
    output div_unit_busy, div_done, div_output
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: restoring shift-subtract, one quotient bit per
// cycle, sequenced by IDLE -> PREP -> CALC (N cycles) -> FIX -> DONE.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : div_sequencer_if slave (request fields in, busy/done/result out)
// With APPROXIMATE=1, DIV/DIVU run 32-a iterations (a = accuracy_level[4:0]) and the quotient
// is shifted left by a, zeroing its a LSBs.
module div_sequencer #(
  parameter bit          APPROXIMATE = 1'b0,
  parameter int unsigned ITER_MAX    = 32
) (
  input  logic           clk,
  input  logic           reset,
  div_sequencer_if.slave bus
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPrep = 3'd1;
  localparam logic [2:0] StCalc = 3'd2;
  localparam logic [2:0] StFix  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;        // funct3[1:0]: bit 1 selects remainder, bit 0 unsigned
  logic [4:0]  shift_q, shift_d;  // approximation shift, 0 at full precision
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;      // holds raw rs1 until PREP, then |rs1|, then quotient
  logic [31:0] dvs_q, dvs_d;      // holds raw rs2 until PREP, then |rs2|
  logic [31:0] out_q, out_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        op_valid;
  logic        accept;
  logic        is_rem;
  logic        is_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] quo_sh;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        unused_acc;

  assign op_valid = bus.start && (bus.opcode == 7'b0110011) && (bus.funct7 == 7'b0000001) &&
                    bus.funct3[2];
  assign accept   = op_valid && ((state_q == StIdle) || (state_q == StDone));

  assign is_rem    = op_q[1];
  assign is_signed = ~op_q[0];

  assign abs_a = (is_signed && quo_q[31]) ? -quo_q : quo_q;
  assign abs_b = (is_signed && dvs_q[31]) ? -dvs_q : dvs_q;

  // Partial remainder never reaches 2*divisor, so bit 32 of the trial is the borrow.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, dvs_q};

  assign quo_sh  = quo_q << shift_q;
  assign quo_fix = qneg_q ? -quo_sh : quo_sh;
  assign rem_fix = rneg_q ? -rem_q : rem_q;

  assign unused_acc = ^bus.accuracy_level[7:5];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    out_d   = out_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    if (bus.flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (accept) begin
            state_d = StPrep;
            op_d    = bus.funct3[1:0];
            shift_d = (APPROXIMATE && !bus.funct3[1]) ? bus.accuracy_level[4:0] : 5'd0;
            quo_d   = bus.bus_rs1;
            dvs_d   = bus.bus_rs2;
            rem_d   = '0;
          end
        end
        StPrep: begin
          if (dvs_q == '0) begin
            out_d   = is_rem ? quo_q : 32'hFFFF_FFFF;
            state_d = StDone;
          end else if (is_signed && (quo_q == 32'h8000_0000) && (dvs_q == 32'hFFFF_FFFF)) begin
            out_d   = is_rem ? 32'h0 : 32'h8000_0000;
            state_d = StDone;
          end else begin
            quo_d   = abs_a;
            dvs_d   = abs_b;
            rem_d   = '0;
            qneg_d  = is_signed & (quo_q[31] ^ dvs_q[31]);
            rneg_d  = is_signed & quo_q[31];
            cnt_d   = 6'(ITER_MAX) - {1'b0, shift_q};
            state_d = StCalc;
          end
        end
        StCalc: begin
          if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d = StFix;
          end
        end
        StFix: begin
          out_d   = is_rem ? rem_fix : quo_fix;
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      out_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      out_q   <= out_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign bus.div_unit_busy = (state_q == StPrep) || (state_q == StCalc) || (state_q == StFix);
  assign bus.div_done      = (state_q == StDone);
  assign bus.div_output    = out_q;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_sequencer_if bus ();

  div_sequencer #(
    .APPROXIMATE(1'b1),
    .ITER_MAX   (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference result computed with the language's own divide operators.
  function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b, input logic [7:0] acc);
    logic [31:0] qa, qb, q, r;
    int          s;
    logic        sgn;
    sgn = ~f3[0];
    if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
    if (f3[1]) begin
      if (sgn) r = $signed(a) % $signed(b);
      else     r = a % b;
      return r;
    end
    s  = int'(acc[4:0]);
    qa = (sgn && a[31]) ? -a : a;
    qb = (sgn && b[31]) ? -b : b;
    q  = ((qa >> s) / qb) << s;
    return (sgn && (a[31] ^ b[31])) ? -q : q;
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b, input logic [7:0] acc);
    if (b == 32'h0) return 2;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 32 - (f3[1] ? 0 : int'(acc[4:0])) + 3;
  endfunction

  function automatic exp_t make_exp(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b, input logic [7:0] acc);
    exp_t e;
    e.res = model_res(f3, a, b, acc);
    e.lat = model_lat(f3, a, b, acc);
    return e;
  endfunction

  // Called at a negedge: drives a start for one cycle, then waits (bounded) for div_done.
  // Returns the result, the cycle index of div_done (0 on timeout) and a count of busy
  // samples that disagreed with "high until done, low at done". Leaves time at that negedge.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] acc, output logic [31:0] res, output int lat,
                       output int bad);
    bus.start          = 1'b1;
    bus.opcode         = 7'b0110011;
    bus.funct7         = 7'b0000001;
    bus.funct3         = f3;
    bus.accuracy_level = acc;
    bus.bus_rs1        = a;
    bus.bus_rs2        = b;
    @(negedge clk);
    bus.start          = 1'b0;
    bus.bus_rs1        = $urandom;
    bus.bus_rs2        = $urandom;
    bus.accuracy_level = 8'($urandom);
    res = 'x;
    lat = 0;
    bad = 0;
    for (int k = 1; k <= 60; k++) begin
      if (bus.div_done) begin
        lat = k;
        res = bus.div_output;
        if (bus.div_unit_busy) bad++;
        break;
      end
      if (!bus.div_unit_busy) bad++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset              = 1'b0;
    bus.start          = 1'b0;
    bus.flush          = 1'b0;
    bus.opcode         = '0;
    bus.funct7         = '0;
    bus.funct3         = '0;
    bus.accuracy_level = '0;
    bus.bus_rs1        = '0;
    bus.bus_rs2        = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.div_unit_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", bus.div_unit_busy);
    end
    checks++;
    if (bus.div_done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", bus.div_done);
    end
    checks++;
    if (bus.div_output !== 32'h0) begin
      errors++; $display("FAIL reset_output: got %h want 0", bus.div_output);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu;
    logic [31:0] r;
    int          l, bad;
    exp_t        e;
    sb.push_back(make_exp(F_DIVU, 32'd100, 32'd7, 8'd0));
    do_op(F_DIVU, 32'd100, 32'd7, 8'd0, r, l, bad);
    e = sb.pop_front();
    checks++;
    if (r !== e.res) begin errors++; $display("FAIL divu_result: got %h want %h", r, e.res); end
    checks++;
    if (l !== e.lat) begin errors++; $display("FAIL divu_latency: got %0d want %0d", l, e.lat); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL divu_busy: %0d bad samples want 0", bad); end
    @(negedge clk);
    checks++;
    if (bus.div_done !== 1'b0) begin
      errors++; $display("FAIL done_strobe_width: got %b want 0", bus.div_done);
    end
    checks++;
    if (bus.div_output !== 32'd14) begin
      errors++; $display("FAIL output_hold: got %h want %h", bus.div_output, 32'd14);
    end
  endtask

  // Table of directed ops: signed, divide-by-zero, overflow, approximate.
  task automatic test_directed;
    logic [2:0]  f3s[10] = '{F_REM, F_DIV, F_DIV, F_REMU, F_DIV, F_REM, F_DIVU, F_REMU,
                             F_DIVU, F_DIV};
    logic [31:0] as[10]  = '{32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd5, 32'd5, 32'h8000_0000,
                             32'h8000_0000, 32'd1000, 32'd1000, 32'hFFFF_FFFF, 32'hFFFF_FF9C};
    logic [31:0] bs[10]  = '{32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3,
                             32'd3, 32'd1, 32'd7};
    logic [7:0]  accs[10] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd4, 8'd4, 8'd31, 8'd2};
    logic [31:0] r;
    int          l, bad;
    exp_t        e;
    for (int i = 0; i < 10; i++) begin
      sb.push_back(make_exp(f3s[i], as[i], bs[i], accs[i]));
      do_op(f3s[i], as[i], bs[i], accs[i], r, l, bad);
      e = sb.pop_front();
      checks++;
      if (r !== e.res) begin
        errors++; $display("FAIL directed%0d_result: got %h want %h", i, r, e.res);
      end
      checks++;
      if (l !== e.lat) begin
        errors++; $display("FAIL directed%0d_latency: got %0d want %0d", i, l, e.lat);
      end
      checks++;
      if (bad !== 0) begin
        errors++; $display("FAIL directed%0d_busy: %0d bad samples want 0", i, bad);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_invalid;
    bus.start  = 1'b1;
    bus.opcode = 7'b0110011;
    bus.funct7 = 7'b0000000;
    bus.funct3 = F_DIV;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.div_unit_busy !== 1'b0) begin
      errors++; $display("FAIL invalid_funct7_busy: got %b want 0", bus.div_unit_busy);
    end
    bus.start  = 1'b1;
    bus.funct7 = 7'b0000001;
    bus.funct3 = 3'b011;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.div_unit_busy !== 1'b0) begin
      errors++; $display("FAIL invalid_funct3_busy: got %b want 0", bus.div_unit_busy);
    end
    @(negedge clk);
    checks++;
    if (bus.div_done !== 1'b0) begin
      errors++; $display("FAIL invalid_done: got %b want 0", bus.div_done);
    end
  endtask

  task automatic test_start_ignored;
    int          l;
    logic [31:0] r;
    exp_t        e;
    sb.push_back(make_exp(F_DIVU, 32'd100, 32'd7, 8'd0));
    bus.start  = 1'b1;
    bus.opcode = 7'b0110011;
    bus.funct7 = 7'b0000001;
    bus.funct3 = F_DIVU;
    bus.accuracy_level = 8'd0;
    bus.bus_rs1 = 32'd100;
    bus.bus_rs2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    // Second request lands while the first is calculating.
    bus.start   = 1'b1;
    bus.bus_rs1 = 32'd9;
    bus.bus_rs2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    l = 0;
    r = 'x;
    for (int k = 3; k <= 60; k++) begin
      if (bus.div_done) begin
        l = k;
        r = bus.div_output;
        break;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if (r !== e.res) begin errors++; $display("FAIL ignored_result: got %h want %h", r, e.res); end
    checks++;
    if (l !== e.lat) begin
      errors++; $display("FAIL ignored_latency: got %0d want %0d", l, e.lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  f3;
    logic [31:0] a, b, r;
    logic [7:0]  acc;
    int          l, bad;
    exp_t        e;
    // Each new start is driven in the DONE cycle of the previous op.
    for (int i = 0; i < 12; i++) begin
      f3  = 3'b100 | 3'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 31);
      acc = 8'($urandom_range(0, 40));
      if (i == 3) b = 32'h0;
      sb.push_back(make_exp(f3, a, b, acc));
      do_op(f3, a, b, acc, r, l, bad);
      e = sb.pop_front();
      checks++;
      if (r !== e.res) begin
        errors++;
        $display("FAIL b2b%0d_result: f3=%b a=%h b=%h acc=%0d got %h want %h", i, f3, a, b,
                 acc, r, e.res);
      end
      checks++;
      if (l !== e.lat) begin
        errors++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, l, e.lat);
      end
      checks++;
      if (bad !== 0) begin
        errors++; $display("FAIL b2b%0d_busy: %0d bad samples want 0", i, bad);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_flush_reset;
    logic [31:0] prior;
    int          dones;
    prior = bus.div_output;
    // Flush at T+10 of a DIVU.
    bus.start  = 1'b1;
    bus.opcode = 7'b0110011;
    bus.funct7 = 7'b0000001;
    bus.funct3 = F_DIVU;
    bus.accuracy_level = 8'd0;
    bus.bus_rs1 = 32'd1000;
    bus.bus_rs2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.div_unit_busy !== 1'b0) begin
      errors++; $display("FAIL flush_busy: got %b want 0", bus.div_unit_busy);
    end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_done) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL flush_no_done: got %0d want 0", dones); end
    checks++;
    if (bus.div_output !== prior) begin
      errors++; $display("FAIL flush_output_kept: got %h want %h", bus.div_output, prior);
    end
    // Flush and start together: start dropped.
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checks++;
    if (bus.div_unit_busy !== 1'b0) begin
      errors++; $display("FAIL flush_start_busy: got %b want 0", bus.div_unit_busy);
    end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL flush_start_no_done: got %0d want 0", dones);
    end
    // Reset low at T+5 of a new op.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.div_unit_busy !== 1'b0) begin
      errors++; $display("FAIL midreset_busy: got %b want 0", bus.div_unit_busy);
    end
    checks++;
    if (bus.div_done !== 1'b0) begin
      errors++; $display("FAIL midreset_done: got %b want 0", bus.div_done);
    end
    checks++;
    if (bus.div_output !== 32'h0) begin
      errors++; $display("FAIL midreset_output: got %h want 0", bus.div_output);
    end
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL midreset_no_done: got %0d want 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_directed();
    test_invalid();
    test_start_ignored();
    test_back_to_back();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle RV32M divide/remainder unit with its own sequencing FSM and shift-subtract datapath.
- Executes DIV, DIVU, REM and REMU and produces 1 quotient bit per cycle.
- Sits in the execute stage beside the multiplier. Stalls the pipeline through div_unit_busy and returns the result with a one-cycle done strobe.
- Optional approximate mode shortens the iteration count for quotient operations under CSR control.

Parameters:
- APPROXIMATE, 0, 1 enables early termination of DIV/DIVU driven by accuracy_level; 0 always runs full precision.
- ITER_MAX, 32, number of CALC iterations at full precision; fixed to the operand width.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; operands and instruction fields are sampled on this edge.
- flush  input  1  pipeline flush; aborts any operation in progress.
- opcode  input  7  instruction opcode.
- funct7  input  7  instruction funct7.
- funct3  input  3  instruction funct3.
- accuracy_level  input  8  approximation level from CSR; only bits [4:0] are used.
- bus_rs1  input  32  dividend.
- bus_rs2  input  32  divisor.
- div_unit_busy  output  1  high while an operation is in flight.
- div_done  output  1  one-cycle strobe; div_output is valid in the same cycle.
- div_output  output  32  registered result; holds its value until the next div_done.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; div_unit_busy=0, div_done=0, div_output=0; all internal registers cleared. Reset mid-operation discards the operation and produces no done strobe.
- Decode: the operation is valid only when opcode=0110011 and funct7=0000001 and funct3[2]=1.
  - funct3=100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - start with an invalid decode is ignored; state does not change.
- start is accepted only in IDLE or DONE. It is ignored in PREP, CALC and FIX.
- States:
  - IDLE: wait for start.
  - PREP (1 cycle):
    - Signed ops take |rs1| and |rs2| and record the quotient sign (rs1[31]^rs2[31]) and the remainder sign (rs1[31]).
    - Divide-by-zero (rs2=0): go directly to DONE with quotient=0xFFFFFFFF and remainder=rs1.
    - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): go directly to DONE with quotient=0x80000000 and remainder=0.
    - Otherwise load counter=N and go to CALC.
  - CALC (N cycles): restoring step, one per cycle.
    - Shift {rem,quo} left by 1 and trial-subtract the divisor.
    - If the trial result is non-negative, keep it and set the quotient LSB to 1; else set the quotient LSB to 0.
    - Decrement counter; leave to FIX when counter reaches 0.
  - FIX (1 cycle): apply the recorded signs (two's complement negate) and select quotient or remainder.
  - DONE (1 cycle): div_done=1, div_output updated; next state IDLE, or PREP if a new valid start arrives.
- Iteration count N:
  - N=32 unless APPROXIMATE=1 and the op is DIV/DIVU.
  - Approximate case: N=32-a with a=min(accuracy_level[4:0],31). The quotient is left-shifted by a after CALC, so its a LSBs are 0.
  - REM/REMU always run N=32.
- div_unit_busy=1 in PREP, CALC and FIX; 0 in IDLE and DONE.
- Latency, with start sampled at cycle T:
  - Normal op: div_done at T+N+3 (full precision: T+35).
  - Special case (divide-by-zero or overflow): div_done at T+2.
- flush, synchronous with priority over start: any state goes to IDLE on the next edge, busy drops, no div_done, div_output unchanged.
  - flush and start in the same cycle: flush wins and start is dropped.
- Operands are held internally; changes on bus_rs1/bus_rs2 after the start edge have no effect.

Test Plan:
- DIVU rs1=100, rs2=7, full precision -> div_done at T+35, div_output=14; busy high T+1..T+34.
- REM rs1=0xFFFFFF9C (-100), rs2=7 -> div_output=0xFFFFFFFE (-2). DIV on the same operands -> 0xFFFFFFF2 (-14).
- DIV rs1=5, rs2=0 -> div_done at T+2, div_output=0xFFFFFFFF. REMU with the same operands -> 5.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> div_output=0x80000000 at T+2. REM with the same operands -> 0.
- APPROXIMATE=1, accuracy_level=4, DIVU 1000/3 -> div_done at T+31, div_output=0x140 (320). REMU 1000/3 with the same setting -> T+35, div_output=1.
- Assert flush at T+10 of a DIVU -> IDLE at T+11, busy=0, no div_done, div_output keeps its prior value. Then reset low at T+5 of a new op -> all outputs 0 immediately.
